// File: rtl/set_cmd_dispatcher.sv
// set_cmd_dispatcher: front end and result collector for the SET circle-candidate
// counter. It assembles 5-byte command frames into SET operands, starts one SET run
// at a time, and queues each tagged result (or timeout marker) in a small FIFO.
module set_cmd_dispatcher #(
  parameter int RES_DEPTH = 4,    // result FIFO depth, power of 2, >= 2
  parameter int TIMEOUT   = 100   // WAIT cycles before a timeout result, >= 70
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  input  logic        set_busy,
  input  logic        set_valid,
  input  logic [7:0]  set_candidate,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic [3:0]  res_tag,
  output logic        res_timeout
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [TW-1:0] TMR_END = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_ISSUE,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] tag;
    logic       timeout;
  } res_t;

  state_t        state, next_state;
  logic [2:0]    byte_cnt;
  logic [1:0]    sh_mode;
  logic [11:0]   sh_radius;
  logic [23:0]   sh_central;
  logic [3:0]    tag;
  logic [TW-1:0] timer;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  res_t          fifo_mem [RES_DEPTH];
  res_t          push_entry;
  res_t          head;

  logic byte_fire;
  logic last_byte;
  logic issue_go;
  logic got_result;
  logic timed_out;
  logic push;
  logic pop;

  // B0[5:4] carries no information in the frame format.
  logic unused_b0_bits;
  assign unused_b0_bits = ^in_data[5:4];

  assign in_ready   = (state == S_COLLECT);
  assign byte_fire  = in_valid && in_ready;
  assign last_byte  = byte_fire && (byte_cnt == 3'd4);
  // A free FIFO slot is reserved before issuing, so the single outstanding run
  // can always push its result.
  assign issue_go   = (state == S_ISSUE) && (count < DEPTH_C) && !set_busy;
  // A real result beats a timeout that lands in the same cycle.
  assign got_result = (state == S_WAIT) && set_valid;
  assign timed_out  = (state == S_WAIT) && !set_valid && (timer == TMR_END);
  assign push       = got_result || timed_out;
  assign pop        = res_valid && res_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_COLLECT;
    else     state <= next_state;
  end

  // Next-state logic.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_COLLECT: if (last_byte) next_state = S_ISSUE;
      S_ISSUE:   if (issue_go)  next_state = S_WAIT;
      S_WAIT:    if (push)      next_state = S_COLLECT;
      default:   next_state = S_COLLECT;
    endcase
  end

  // Frame assembly: each accepted byte lands in its slot of the shadow fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= 3'd0;
      sh_mode    <= 2'd0;
      sh_radius  <= 12'd0;
      sh_central <= 24'd0;
    end else if (byte_fire) begin
      case (byte_cnt)
        3'd0: begin
          sh_mode         <= in_data[7:6];
          sh_radius[11:8] <= in_data[3:0];
        end
        3'd1:    sh_radius[7:0]    <= in_data;
        3'd2:    sh_central[23:16] <= in_data;
        3'd3:    sh_central[15:8]  <= in_data;
        3'd4:    sh_central[7:0]   <= in_data;
        default: ;
      endcase
      byte_cnt <= last_byte ? 3'd0 : byte_cnt + 3'd1;
    end
  end

  // Operand launch: one-cycle start pulse; operands hold until the next issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_en      <= 1'b0;
      set_central <= 24'd0;
      set_radius  <= 12'd0;
      set_mode    <= 2'd0;
    end else begin
      set_en <= issue_go;
      if (issue_go) begin
        set_central <= sh_central;
        set_radius  <= sh_radius;
        set_mode    <= sh_mode;
      end
    end
  end

  // Run timer: cleared at issue, counts every WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  timer <= '0;
    else if (issue_go)        timer <= '0;
    else if (state == S_WAIT) timer <= timer + TMR_ONE;
  end

  // Command sequence number, advanced once per queued result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tag <= 4'd0;
    else if (push) tag <= tag + 4'd1;
  end

  assign push_entry = '{data:    got_result ? set_candidate : 8'h00,
                        tag:     tag,
                        timeout: !got_result};

  // FIFO pointers and occupancy; pointers wrap naturally at RES_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // FIFO storage write.
  // NOTE: the storage array is deliberately not reset; occupancy is tracked by
  // count, and the outputs below are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  assign head        = fifo_mem[rd_ptr];
  assign res_valid   = (count != '0);
  assign res_data    = res_valid ? head.data    : 8'h00;
  assign res_tag     = res_valid ? head.tag     : 4'h0;
  assign res_timeout = res_valid ? head.timeout : 1'b0;

endmodule

// File: tb/tb_set_cmd_dispatcher.sv
// Bench for set_cmd_dispatcher: a behavioural SET model answers each run, and a
// scoreboard of expected results (built from the frames sent) is checked by an
// independent monitor whenever the consumer pops an entry.
module tb_set_cmd_dispatcher;

  localparam int RES_DEPTH = 4;
  localparam int TIMEOUT   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy = 1'b0;
  logic        set_valid = 1'b0;
  logic [7:0]  set_candidate = 8'h00;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_data;
  logic [3:0]  res_tag;
  logic        res_timeout;

  always #5 clk = ~clk;

  set_cmd_dispatcher #(.RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_timeout(res_timeout)
  );

  typedef struct {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    bit          hang;   // SET never answers; busy held past the timeout
    int          lat;    // answer cycle (or busy-drop cycle when hanging)
    bit          late;   // hanging job fires a stray set_valid before busy drops
  } job_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] tag;
    logic       timeout;
  } exp_t;

  job_t job_q[$];
  exp_t exp_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int en_count   = 0;
  bit rr_random  = 0;
  logic [3:0] tag_ctr = 4'd0;

  bit          m_active = 0;
  job_t        m_job;
  int          m_t = 0;
  logic [23:0] m_central;
  logic [11:0] m_radius;
  logic [1:0]  m_mode;
  int          last_en_cyc = 0;
  int          last_lat = 0;
  bit          last_hang = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Candidate count of an 8x8 grid (coords 1..8) against up to three circles.
  function automatic int ref_count(input logic [23:0] c, input logic [11:0] r,
                                   input logic [1:0] m);
    int cnt;
    cnt = 0;
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        bit in_c [3];
        int cx, cy, rk, d;
        for (int k = 0; k < 3; k++) begin
          cx = int'(c[23-8*k -: 4]);
          cy = int'(c[19-8*k -: 4]);
          rk = int'(r[11-4*k -: 4]);
          d  = (x - cx) * (x - cx) + (y - cy) * (y - cy);
          in_c[k] = (d <= rk * rk);
        end
        case (m)
          2'd0:    if (in_c[0]) cnt++;
          2'd1:    if (in_c[0] && in_c[1]) cnt++;
          2'd2:    if (in_c[0] != in_c[1]) cnt++;
          default: if (int'(in_c[0]) + int'(in_c[1]) + int'(in_c[2]) >= 2) cnt++;
        endcase
      end
    end
    return cnt;
  endfunction

  function automatic logic [39:0] rand_frame();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[39:0];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (!acc) bound_fail("byte_accept");
  endtask

  // Queue the job and its expected result, then stream the 5 bytes.
  task automatic send_frame(input logic [39:0] f, input bit hang, input int lat,
                            input bit late, input bit gaps, input int exp_data);
    job_t j;
    exp_t e;
    j.mode    = f[39:38];
    j.radius  = {f[35:32], f[31:24]};
    j.central = f[23:0];
    j.hang    = hang;
    j.lat     = lat;
    j.late    = late;
    e.data    = hang ? 8'h00 : (exp_data >= 0 ? 8'(exp_data)
                                              : 8'(ref_count(j.central, j.radius, j.mode)));
    e.tag     = tag_ctr;
    e.timeout = hang;
    tag_ctr   = tag_ctr + 4'd1;
    job_q.push_back(j);
    exp_q.push_back(e);
    for (int i = 0; i < 5; i++) begin
      send_byte(f[39-8*i -: 8]);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_set_en",      set_en,      0);
    check("rst_set_central", set_central, 0);
    check("rst_set_radius",  set_radius,  0);
    check("rst_set_mode",    set_mode,    0);
    check("rst_res_valid",   res_valid,   0);
    check("rst_res_data",    res_data,    0);
    check("rst_res_tag",     res_tag,     0);
    check("rst_res_timeout", res_timeout, 0);
    job_q.delete();
    exp_q.delete();
    tag_ctr = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || job_q.size() != 0 || m_active) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) bound_fail(name);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // SET model: answers each run after its latency, checks operands stay put.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      set_valid     = 1'b0;
      set_candidate = 8'($urandom);
      if (rst) begin
        m_active = 0;
        set_busy = 1'b0;
      end else begin
        if (set_en === 1'b1) begin
          check("issue_while_busy", set_busy, 0);
          en_count++;
          if (job_q.size() == 0) begin
            bound_fail("spurious_set_en");
          end else begin
            m_job = job_q.pop_front();
            check("op_central", set_central, m_job.central);
            check("op_radius",  set_radius,  m_job.radius);
            check("op_mode",    set_mode,    m_job.mode);
            m_central   = set_central;
            m_radius    = set_radius;
            m_mode      = set_mode;
            m_active    = 1;
            m_t         = 0;
            last_en_cyc = cyc;
            last_lat    = m_job.lat;
            last_hang   = m_job.hang;
          end
        end else if (m_active) begin
          m_t++;
          check("op_stable", {set_mode, set_radius, set_central},
                {m_mode, m_radius, m_central});
        end
        if (m_active) begin
          if (m_t == m_job.lat) begin
            set_busy = 1'b0;
            m_active = 0;
            if (!m_job.hang) begin
              set_valid     = 1'b1;
              set_candidate = 8'(ref_count(m_central, m_radius, m_mode));
            end
          end else begin
            set_busy = 1'b1;
            if (m_job.hang && m_job.late && m_t == m_job.lat - 1) set_valid = 1'b1;
          end
        end
      end
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_random) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: result latency on FIFO fill, in_ready while running, popped entries.
  initial begin
    bit prev_rv;
    exp_t e;
    prev_rv = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rv = 0;
      end else begin
        if (res_valid && !prev_rv && exp_q.size() > 0)
          check("result_latency", cyc - last_en_cyc, last_hang ? TIMEOUT : last_lat + 1);
        if (set_en === 1'b1) check("in_ready_in_wait", in_ready, 0);
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            bound_fail("unexpected_result");
          end else begin
            e = exp_q.pop_front();
            check("res_data",    res_data,    e.data);
            check("res_tag",     res_tag,     e.tag);
            check("res_timeout", res_timeout, e.timeout);
          end
        end
        prev_rv = res_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_base;
    int n;

    do_reset();

    // Single mode-0 frame: circle at (4,4) radius 3 holds 29 grid points.
    res_ready = 1'b1;
    send_frame(40'h03_00_44_00_00, 0, 10, 0, 0, 29);
    wait_drain("drain_single");

    // Gapped byte stream, next frame held valid through ISSUE/WAIT.
    rr_random = 1;
    for (int i = 0; i < 6; i++)
      send_frame(rand_frame(), 0, $urandom_range(1, 30), 0, 1, -1);
    wait_drain("drain_gaps");

    // Timeouts with late pulses and busy blocking, tie case, minimum latency.
    rr_random = 0;
    res_ready = 1'b1;
    send_frame(rand_frame(), 1, $urandom_range(TIMEOUT + 8, TIMEOUT + 20), 1, 0, -1);
    send_frame(rand_frame(), 1, $urandom_range(TIMEOUT + 8, TIMEOUT + 20), 0, 1, -1);
    send_frame(rand_frame(), 0, TIMEOUT - 1, 0, 0, -1);
    send_frame(rand_frame(), 0, 1, 0, 1, -1);
    wait_drain("drain_timeout");

    // Full FIFO: fifth command must stall in ISSUE until one pop.
    res_ready = 1'b0;
    en_base = en_count;
    for (int i = 0; i < 5; i++)
      send_frame(rand_frame(), 0, $urandom_range(1, 10), 0, 0, -1);
    repeat (40) @(posedge clk);
    #1;
    check("full_issue_count", en_count - en_base, 4);
    check("full_res_valid", res_valid, 1);
    check("full_in_ready", in_ready, 0);
    check("full_set_en", set_en, 0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("after_pop_issue_count", en_count - en_base, 5);
    res_ready = 1'b1;
    wait_drain("drain_full");

    // 18 commands popped as they arrive: tag wraps.
    for (int i = 0; i < 18; i++)
      send_frame(rand_frame(), 0, $urandom_range(1, 12), 0, $urandom_range(0, 1) == 1, -1);
    wait_drain("drain_wrap");

    // Mixed random traffic with random back-pressure.
    rr_random = 1;
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 4) == 0)
        send_frame(rand_frame(), 1, $urandom_range(TIMEOUT + 8, TIMEOUT + 20),
                   $urandom_range(0, 1) == 1, 1, -1);
      else
        send_frame(rand_frame(), 0, $urandom_range(1, TIMEOUT - 1), 0, 1, -1);
    end
    wait_drain("drain_mixed");

    // Reset in the middle of a frame.
    rr_random = 0;
    res_ready = 1'b1;
    send_byte(8'h5a);
    send_byte(8'ha5);
    do_reset();
    send_frame(rand_frame(), 0, $urandom_range(1, 20), 0, 0, -1);
    wait_drain("drain_rst_frame");

    // Reset during WAIT with a result sitting in the FIFO.
    res_ready = 1'b0;
    en_base = en_count;
    send_frame(rand_frame(), 0, 3, 0, 0, -1);
    send_frame(rand_frame(), 1, TIMEOUT + 10, 0, 0, -1);
    n = 0;
    while (en_count - en_base < 2 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) bound_fail("wait_second_issue");
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_res_valid", res_valid, 1);
    do_reset();
    check("post_rst_res_valid", res_valid, 0);
    res_ready = 1'b1;
    send_frame(40'h03_00_44_00_00, 0, 7, 0, 0, 29);
    wait_drain("drain_rst_wait");

    check("end_res_valid", res_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
